// File: rtl/scmp_mem_ref_unit.sv
// scmp_mem_ref_unit: memory-reference engine for the SC/MP core.
// Computes the paged effective address, applies auto-indexing, runs the
// bus read / write / read-modify-write with wait states and a timeout,
// and returns the data byte plus the updated pointer.
module scmp_mem_ref_unit #(
   parameter int ADDR_W    = 16,
   parameter int PAGE_BITS = 12,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        opcode,
   input  logic [ADDR_W-1:0] ptr,
   input  logic [7:0]        disp,
   input  logic [7:0]        e_reg,
   input  logic [7:0]        ac,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        result,
   output logic              ptr_wr_en,
   output logic [ADDR_W-1:0] ptr_wr_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RMW_WR, S_DONE} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic                rmw_q, dec_q, st_q, idx_q;

   logic                is_rd, is_st, is_rmw, is_dec, illegal;
   logic [7:0]          off;
   logic [PAGE_BITS-1:0] sum;
   logic [ADDR_W-1:0]   np, ea;
   logic [7:0]          mod_byte;
   logic                unused_sel;

   // Pointer select is resolved by the core before ptr reaches us.
   assign unused_sel = ^opcode[1:0];

   // Opcode class decode and legality.
   always_comb begin
      is_rd  = 1'b0;
      is_st  = 1'b0;
      is_rmw = 1'b0;
      is_dec = 1'b0;
      case (opcode[7:3])
         5'b11000, 5'b11010, 5'b11011, 5'b11100,
         5'b11101, 5'b11110, 5'b11111: is_rd = 1'b1;
         5'b11001:                     is_st = 1'b1;
         5'b10101:                     is_rmw = 1'b1;
         5'b10111: begin is_rmw = 1'b1; is_dec = 1'b1; end
         default: ;
      endcase
   end

   assign illegal = !(is_rd || is_st || is_rmw) || (opcode[2:0] == 3'b100) ||
                    (is_rmw && opcode[2]);

   // Paged address arithmetic: only the low PAGE_BITS take part, no carry out.
   assign off      = (disp == 8'h80) ? e_reg : disp;
   assign sum      = ptr[PAGE_BITS-1:0] + {{(PAGE_BITS-8){off[7]}}, off};
   assign np       = {ptr[ADDR_W-1:PAGE_BITS], sum};
   // Auto-index: negative offset pre-decrements, non-negative post-increments.
   assign ea       = (opcode[2] && !off[7]) ? ptr : np;
   assign mod_byte = dec_q ? (mem_rdata - 8'd1) : (mem_rdata + 8'd1);

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         rmw_q       <= 1'b0;
         dec_q       <= 1'b0;
         st_q        <= 1'b0;
         idx_q       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         result      <= '0;
         ptr_wr_en   <= 1'b0;
         ptr_wr_data <= '0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
         mem_wdata   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  cnt  <= '0;
                  if (illegal) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state       <= S_ACCESS;
                     rmw_q       <= is_rmw;
                     dec_q       <= is_dec;
                     st_q        <= is_st;
                     idx_q       <= opcode[2];
                     ptr_wr_data <= np;
                     mem_addr    <= ea;
                     mem_wdata   <= ac;
                     mem_rd      <= !is_st;
                     mem_wr      <= is_st;
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ready) begin
                  mem_rd <= 1'b0;
                  cnt    <= '0;
                  if (rmw_q) begin
                     state     <= S_RMW_WR;
                     mem_wr    <= 1'b1;
                     mem_wdata <= mod_byte;
                  end else begin
                     state     <= S_DONE;
                     mem_wr    <= 1'b0;
                     done      <= 1'b1;
                     result    <= st_q ? 8'h00 : mem_rdata;
                     ptr_wr_en <= idx_q;
                  end
               end else if (cnt == CNT_LAST) begin
                  state  <= S_DONE;
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  done   <= 1'b1;
                  err    <= 1'b1;
                  result <= 8'h00;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RMW_WR: begin
               if (mem_ready) begin
                  state     <= S_DONE;
                  mem_wr    <= 1'b0;
                  done      <= 1'b1;
                  result    <= mem_wdata;
                  ptr_wr_en <= idx_q;
               end else if (cnt == CNT_LAST) begin
                  state  <= S_DONE;
                  mem_wr <= 1'b0;
                  done   <= 1'b1;
                  err    <= 1'b1;
                  result <= 8'h00;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               // DONE: pulses end, back to IDLE; a start seen here is dropped.
               state     <= S_IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               err       <= 1'b0;
               result    <= 8'h00;
               ptr_wr_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scmp_mem_ref_unit.sv
// tb_scmp_mem_ref_unit: directed vectors with a response/bus scoreboard.
module tb_scmp_mem_ref_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  opcode = '0;
   logic [15:0] ptr = '0;
   logic [7:0]  disp = '0, e_reg = '0, ac = '0;
   logic        busy, done, err, ptr_wr_en, mem_rd, mem_wr, mem_ready;
   logic [7:0]  result, mem_wdata, mem_rdata;
   logic [15:0] ptr_wr_data, mem_addr;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int wait_n = 0;
   logic hang = 1'b0;
   int waitc = 0;
   int rd_cnt = 0, wr_cnt = 0;
   logic [7:0] mem [0:65535];

   typedef struct {
      logic [7:0]  res;
      logic        err;
      logic        pen;
      logic [15:0] pdata;
      int          cyc;
   } resp_t;
   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  data;
   } bus_t;

   resp_t resp_q[$];
   bus_t  bus_q[$];

   scmp_mem_ref_unit #(.ADDR_W(16), .PAGE_BITS(12), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ptr(ptr),
      .disp(disp), .e_reg(e_reg), .ac(ac), .busy(busy), .done(done),
      .err(err), .result(result), .ptr_wr_en(ptr_wr_en),
      .ptr_wr_data(ptr_wr_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Memory model with programmable wait states.
   assign mem_ready = (mem_rd || mem_wr) && !hang && (waitc >= wait_n);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if ((mem_rd || mem_wr) && !mem_ready) waitc <= waitc + 1;
      else waitc <= 0;
      if (mem_wr && mem_ready) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare bus handshakes and completions against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd) rd_cnt++;
         if (mem_wr) wr_cnt++;
         if (mem_rd && mem_wr) chk("strobe_overlap", 1, 0);
         if ((mem_rd || mem_wr) && mem_ready) begin
            if (bus_q.size() == 0) chk("unexpected_bus", 1, 0);
            else begin
               bus_t b;
               b = bus_q.pop_front();
               chk("bus_wr", {31'd0, mem_wr}, {31'd0, b.wr});
               chk("bus_addr", {16'd0, mem_addr}, {16'd0, b.addr});
               if (b.wr) chk("bus_wdata", {24'd0, mem_wdata}, {24'd0, b.data});
            end
         end
         if (done) begin
            if (resp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               resp_t r;
               r = resp_q.pop_front();
               chk("result", {24'd0, result}, {24'd0, r.res});
               chk("err", {31'd0, err}, {31'd0, r.err});
               chk("ptr_wr_en", {31'd0, ptr_wr_en}, {31'd0, r.pen});
               chk("busy_at_done", {31'd0, busy}, 32'd1);
               if (r.pen) chk("ptr_wr_data", {16'd0, ptr_wr_data}, {16'd0, r.pdata});
               chk("latency", cyc, r.cyc);
            end
         end
      end
   end

   task automatic exp_bus(input logic wr, input logic [15:0] a, input logic [7:0] d);
      bus_t b;
      b.wr = wr; b.addr = a; b.data = d;
      bus_q.push_back(b);
   endtask

   // Issue one request; hold keeps start high extra cycles while busy.
   task automatic op(input logic [7:0] opc, input logic [15:0] p, input logic [7:0] d,
                     input logic [7:0] e, input logic [7:0] a, input logic [7:0] xres,
                     input logic xerr, input logic xpen, input logic [15:0] xpd,
                     input int lat, input int hold);
      resp_t r;
      bit    seen;
      @(negedge clk);
      opcode = opc; ptr = p; disp = d; e_reg = e; ac = a; start = 1'b1;
      r.res = xres; r.err = xerr; r.pen = xpen; r.pdata = xpd; r.cyc = cyc + lat;
      resp_q.push_back(r);
      repeat (1 + hold) @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h1003] = 8'h3C;
      mem[16'h0200] = 8'hA7;
      mem[16'h0304] = 8'hFF;
      mem[16'h0600] = 8'h11;

      // Reset state.
      #1;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 0);
      chk("rst_ptr_wr_en", {31'd0, ptr_wr_en}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // LD with page wrap, no auto-index.
      exp_bus(1'b0, 16'h1003, 8'h00);
      op(8'hC1, 16'h1FFE, 8'h05, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0, 16'h0000, 2, 0);
      // ST auto-index pre-decrement.
      exp_bus(1'b1, 16'h0F1F, 8'h5A);
      op(8'hCD, 16'h0F20, 8'hFF, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 16'h0F1F, 2, 0);
      // Read back the stored byte.
      exp_bus(1'b0, 16'h0F1F, 8'h00);
      op(8'hC0, 16'h0F1F, 8'h00, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 16'h0000, 2, 0);
      // LD auto-index post-increment using E as offset.
      exp_bus(1'b0, 16'h0200, 8'h00);
      op(8'hC6, 16'h0200, 8'h80, 8'h10, 8'h00, 8'hA7, 1'b0, 1'b1, 16'h0210, 2, 0);
      // ILD with 2 wait states per access; second start while busy is ignored.
      wait_n = 2;
      exp_bus(1'b0, 16'h0304, 8'h00);
      exp_bus(1'b1, 16'h0304, 8'h00);
      op(8'hAA, 16'h0300, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 7, 1);
      wait_n = 0;
      // DLD wraps 00 -> FF.
      exp_bus(1'b0, 16'h0400, 8'h00);
      exp_bus(1'b1, 16'h0400, 8'hFF);
      op(8'hB8, 16'h0400, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 16'h0000, 3, 0);
      chk("dld_mem", {24'd0, mem[16'h0400]}, 32'hFF);

      // Timeout: 4 read cycles, no write, no pointer update.
      hang = 1'b1;
      rd_cnt = 0; wr_cnt = 0;
      op(8'hC5, 16'h0500, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 5, 0);
      chk("timeout_rd_cycles", rd_cnt, 4);
      chk("timeout_wr_cycles", wr_cnt, 0);
      hang = 1'b0;

      // Illegal requests: immediate form, unknown class, auto-indexed DLD.
      rd_cnt = 0; wr_cnt = 0;
      op(8'hC4, 16'h0100, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1, 0);
      op(8'h08, 16'h0100, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1, 0);
      op(8'hBC, 16'h0100, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1, 0);
      chk("illegal_no_strobe", rd_cnt + wr_cnt, 0);

      // Reset during the ILD write phase.
      wait_n = 2;
      exp_bus(1'b0, 16'h0600, 8'h00);
      @(negedge clk);
      opcode = 8'hA8; ptr = 16'h0600; disp = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (mem_wr) break;
         @(negedge clk);
      end
      chk("rmw_wr_reached", {31'd0, mem_wr}, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_wr", {31'd0, mem_wr}, 0);
      chk("rst_mid_busy", {31'd0, busy}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_mem_untouched", {24'd0, mem[16'h0600]}, 32'h11);
      chk("resp_q_empty", resp_q.size(), 0);
      chk("bus_q_empty", bus_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
